// File: rtl/shader_seq_pkg.sv
// Shared types for the shader instruction-memory sequencer.
package shader_seq_pkg;

   localparam int NUM_INSTR_DEFAULT = 10;

   typedef logic [7:0] instr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      LOAD = 2'd2
   } state_t;

endpackage

// File: rtl/shader_sequencer.sv
// Drives the shift/load port of the circular shader instruction memory.
// Optional single-step execution via SHADER_SEQ_SINGLE_STEP_EN.
//
// state | meaning
// IDLE  | memory aligned (entry 0 = first instruction), waiting for pixel or load
// EXEC  | rotating memory once per instruction for the current pixel
// LOAD  | accepting NUM_INSTR program bytes, shifted in with load asserted
module shader_sequencer
   import shader_seq_pkg::*;
#(
   parameter int NUM_INSTR = NUM_INSTR_DEFAULT,
   localparam int CNT_W = $clog2(NUM_INSTR + 1)
) (
   input  logic   clk_i,
   input  logic   rst_ni,
`ifdef SHADER_SEQ_SINGLE_STEP_EN
   input  logic   step_mode_i,
   input  logic   step_i,
`endif
   input  logic   pixel_start_i,
   input  logic   blank_i,
   input  logic   wr_valid_i,
   input  instr_t wr_data_i,
   output logic   wr_ready_o,
   output logic   mem_shift_o,
   output logic   mem_load_o,
   output instr_t mem_instr_o,
   output logic   exec_o,
   output logic   pixel_done_o,
   output logic   load_done_o,
   output logic   overrun_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INSTR - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pixel_done;
   logic             r_load_done;
   logic             r_overrun;

   logic w_step_ok;
   logic w_exec_adv;
   logic w_hs;
   logic w_last;

`ifdef SHADER_SEQ_SINGLE_STEP_EN
   assign w_step_ok = !step_mode_i || step_i;
`else
   assign w_step_ok = 1'b1;
`endif

   // Strobes decode from the registered state so they are glitch-free and
   // fall to 0 the instant reset asserts.
   assign w_exec_adv = (r_state == EXEC) && w_step_ok;
   assign w_hs       = (r_state == LOAD) && wr_valid_i;
   assign w_last     = (r_cnt == CNT_LAST);

   assign exec_o       = w_exec_adv;
   assign mem_shift_o  = w_exec_adv || w_hs;
   assign mem_load_o   = w_hs;
   assign mem_instr_o  = w_hs ? wr_data_i : '0;
   assign wr_ready_o   = (r_state == LOAD);
   assign pixel_done_o = r_pixel_done;
   assign load_done_o  = r_load_done;
   assign overrun_o    = r_overrun;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_pixel_done <= 1'b0;
         r_load_done  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_pixel_done <= 1'b0;
         r_load_done  <= 1'b0;
         if (pixel_start_i && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (pixel_start_i) begin
                  r_state <= EXEC;
                  r_cnt   <= '0;
               end else if (wr_valid_i && blank_i) begin
                  r_state <= LOAD;
                  r_cnt   <= '0;
               end
            end
            EXEC: begin
               if (w_exec_adv) begin
                  if (w_last) begin
                     r_state      <= IDLE;
                     r_cnt        <= '0;
                     r_pixel_done <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            LOAD: begin
               // blank_i is deliberately ignored here: a partial load would
               // leave the memory misaligned.
               if (w_hs) begin
                  if (w_last) begin
                     r_state     <= IDLE;
                     r_cnt       <= '0;
                     r_load_done <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shader_sequencer.sv
// Self-checking bench for shader_sequencer with a behavioural circular-memory
// model; covers SHADER_SEQ_SINGLE_STEP_EN when that macro is defined.
module tb_shader_sequencer;

   localparam int N = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pixel_start = 1'b0;
   logic       blank = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready, mem_shift, mem_load, exec_o, pixel_done, load_done, overrun;
   logic [7:0] mem_instr;
`ifdef SHADER_SEQ_SINGLE_STEP_EN
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
`endif

   shader_sequencer #(.NUM_INSTR(N)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
`ifdef SHADER_SEQ_SINGLE_STEP_EN
      .step_mode_i  (step_mode),
      .step_i       (step),
`endif
      .pixel_start_i(pixel_start),
      .blank_i      (blank),
      .wr_valid_i   (wr_valid),
      .wr_data_i    (wr_data),
      .wr_ready_o   (wr_ready),
      .mem_shift_o  (mem_shift),
      .mem_load_o   (mem_load),
      .mem_instr_o  (mem_instr),
      .exec_o       (exec_o),
      .pixel_done_o (pixel_done),
      .load_done_o  (load_done),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   // Reference shader memory: entry 0 is the output, shift rotates toward 0.
   logic [7:0] mem [N];
   logic [7:0] snap [N];
   logic [7:0] prog [N];
   logic [7:0] exec_seen [$];

   int cyc, exec_cnt, hs_cnt, pdone_cnt, ldone_cnt, ready_cnt;
   int first_exec, last_exec, pdone_cyc, ldone_cyc, last_hs;
   int inv_bad = 0, step_bad = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mem_default();
      for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
   endtask

   task automatic reset_meas();
      cyc = 0; exec_cnt = 0; hs_cnt = 0; pdone_cnt = 0; ldone_cnt = 0; ready_cnt = 0;
      first_exec = -1; last_exec = -1; pdone_cyc = -1; ldone_cyc = -1; last_hs = -1;
      exec_seen.delete();
   endtask

   // Called at a negedge with inputs already driven; observes one cycle.
   task automatic tick();
      logic [7:0] head;
      logic       hs;
      #1;
      hs = wr_valid && wr_ready;
      if (mem_load && !mem_shift) inv_bad++;
      if (mem_instr !== (hs ? wr_data : 8'h00)) inv_bad++;
      if (wr_ready && exec_o) inv_bad++;
`ifdef SHADER_SEQ_SINGLE_STEP_EN
      if (exec_o && step_mode && !step) step_bad++;
`endif
      if (exec_o) begin
         exec_seen.push_back(mem[0]);
         if (first_exec < 0) first_exec = cyc;
         last_exec = cyc;
         exec_cnt++;
      end
      if (hs) begin hs_cnt++; last_hs = cyc; end
      if (wr_ready) ready_cnt++;
      if (pixel_done) begin pdone_cnt++; pdone_cyc = cyc; end
      if (load_done) begin ldone_cnt++; ldone_cyc = cyc; end
      if (mem_shift) begin
         head = mem[0];
         for (int i = 0; i < N - 1; i++) mem[i] = mem[i + 1];
         mem[N - 1] = mem_load ? mem_instr : head;
      end
      @(negedge clk);
      cyc++;
   endtask

   function automatic int seq_err();
      int e = 0;
      if (exec_seen.size() != N) return 99;
      for (int i = 0; i < N; i++) if (exec_seen[i] !== prog[i]) e++;
      return e;
   endfunction

   function automatic int mem_err();
      int e = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== prog[i]) e++;
      return e;
   endfunction

   task automatic run_pixel(input int lead, input int ovr_at);
      reset_meas();
      repeat (lead) tick();
      pixel_start = 1'b1;
      tick();
      pixel_start = 1'b0;
      for (int k = 0; k < 200 && pdone_cnt == 0; k++) begin
         pixel_start = (ovr_at >= 0) && (exec_cnt == ovr_at);
`ifdef SHADER_SEQ_SINGLE_STEP_EN
         step = step_mode && (cyc % 3 == 2);
`endif
         tick();
      end
      pixel_start = 1'b0;
`ifdef SHADER_SEQ_SINGLE_STEP_EN
      step = 1'b0;
`endif
   endtask

   task automatic run_load(input int gap_mode, input int drop_at, input int ovr_at);
      reset_meas();
      blank = 1'b1;
      for (int k = 0; k < 400 && ldone_cnt == 0; k++) begin
         if (hs_cnt < N) begin
            wr_valid = (gap_mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            wr_data  = wr_valid ? prog[hs_cnt] : 8'($urandom);
         end else begin
            wr_valid = 1'b0;
         end
         if (drop_at >= 0 && hs_cnt >= drop_at) blank = 1'b0;
         pixel_start = (ovr_at >= 0) && (hs_cnt == ovr_at);
         tick();
      end
      wr_valid = 1'b0; pixel_start = 1'b0; blank = 1'b0;
   endtask

   task automatic check_load(input string tag);
      chk({tag, "_hs"}, hs_cnt, N);
      chk({tag, "_ldone_n"}, ldone_cnt, 1);
      chk({tag, "_ldone_lat"}, ldone_cyc, last_hs + 1);
      chk({tag, "_no_exec"}, exec_cnt, 0);
      chk({tag, "_mem"}, mem_err(), 0);
   endtask

   initial begin
      int lead, errs;
      mem_default();

      // Reset values
      #3;
      chk("reset_outs", int'({exec_o, mem_shift, mem_load, mem_instr, wr_ready,
                              pixel_done, load_done, overrun}), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Pixel from reset: start at cycle 5
      for (int i = 0; i < N; i++) snap[i] = mem[i];
      run_pixel(5, -1);
      chk("px_first", first_exec, 6);
      chk("px_last", last_exec, 15);
      chk("px_count", exec_cnt, N);
      chk("px_done", pdone_cyc, 16);
      chk("px_mem0", int'(mem[0]), 'h10);
      errs = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== snap[i]) errs++;
      chk("px_realign", errs, 0);
      for (int i = 0; i < N; i++) prog[i] = snap[i];
      chk("px_seq", seq_err(), 0);

      // Directed load 0x01..0x0A with toggling valid
      for (int i = 0; i < N; i++) prog[i] = 8'(i + 1);
      run_load(0, -1, -1);
      check_load("ld");
      run_pixel(0, -1);
      chk("ld_px_seq", seq_err(), 0);
      chk("ld_px_done", pdone_cyc, N + 1);

      // Start accepted on the pixel_done cycle
      reset_meas();
      pixel_start = 1'b1; tick(); pixel_start = 1'b0;
      repeat (N) tick();
      pixel_start = 1'b1; tick(); pixel_start = 1'b0;
      for (int k = 0; k < 100 && pdone_cnt < 2; k++) tick();
      chk("b2b_exec", exec_cnt, 2 * N);
      chk("b2b_last", last_exec, 2 * N + 1);
      chk("b2b_done", pdone_cyc, 2 * N + 2);
      chk("b2b_no_ovr", int'(overrun), 0);

      // Write held off outside blanking
      reset_meas();
      wr_valid = 1'b1; wr_data = 8'hAA; blank = 1'b0;
      repeat (5) tick();
      wr_valid = 1'b0;
      chk("hold_ready", ready_cnt, 0);

      // Overrun during EXEC and during LOAD
      run_pixel(1, 3);
      chk("ovr_exec_flag", int'(overrun), 1);
      chk("ovr_exec_count", exec_cnt, N);
      chk("ovr_exec_done", pdone_cyc, N + 2);
      for (int i = 0; i < N; i++) prog[i] = 8'($urandom);
      run_load(1, 6, 5);
      check_load("ovr_ld");
      chk("ovr_ld_flag", int'(overrun), 1);

      // Randomized load/execute rounds
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) prog[i] = 8'($urandom);
         run_load(1, (r == 1) ? 3 : -1, -1);
         check_load("rnd_ld");
         lead = $urandom_range(0, 3);
         run_pixel(lead, -1);
         chk("rnd_seq", seq_err(), 0);
         chk("rnd_done", pdone_cyc, lead + N + 1);
      end

      // Pixel and load request on the same IDLE cycle, then reset mid-LOAD
      for (int i = 0; i < N; i++) prog[i] = 8'(8'h80 + i);
      reset_meas();
      pixel_start = 1'b1; wr_valid = 1'b1; blank = 1'b1; wr_data = prog[0];
      tick();
      pixel_start = 1'b0;
      for (int k = 0; k < 100 && pdone_cnt == 0; k++) tick();
      chk("conc_exec", exec_cnt, N);
      chk("conc_ready", ready_cnt, 0);
      for (int k = 0; k < 100 && hs_cnt < 4; k++) begin
         wr_data = prog[hs_cnt];
         tick();
      end
      chk("conc_hs4", hs_cnt, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_outs", int'({exec_o, mem_shift, mem_load, mem_instr, wr_ready,
                                  pixel_done, load_done, overrun}), 0);
      wr_valid = 1'b0; blank = 1'b0;
      mem_default();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      reset_meas();
      wr_valid = 1'b1; wr_data = 8'h55;
      repeat (3) tick();
      wr_valid = 1'b0;
      chk("rst_idle_ready", ready_cnt, 0);
      for (int i = 0; i < N; i++) prog[i] = 8'h10 + 8'(i);
      run_pixel(2, -1);
      chk("rst_px_first", first_exec, 3);
      chk("rst_px_seq", seq_err(), 0);

`ifdef SHADER_SEQ_SINGLE_STEP_EN
      step_mode = 1'b1;
      run_pixel(0, -1);
      step_mode = 1'b0;
      chk("step_count", exec_cnt, N);
      chk("step_coinc", step_bad, 0);
      chk("step_last", last_exec, 29);
      chk("step_done", pdone_cyc, last_exec + 1);
      chk("step_seq", seq_err(), 0);
`endif

      chk("invariants", inv_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/shader_sequencer.md
Name: shader_sequencer

Overview:
Controller that drives the shift/load port of the shader instruction memory, a circular shift register with NUM_INSTR entries. It has two jobs:
- Per pixel, it rotates the memory once per instruction so the core executes the whole program.
- During blanking, it streams a new program in from a byte source over a valid/ready handshake.

It sits between the pixel timing/SPI front end and the shader memory, and guarantees the memory is always back at alignment (entry 0 = first instruction) whenever it is idle.

Parameters:
NUM_INSTR, 10, program length in instructions; must match the memory depth.
CNT_W, $clog2(NUM_INSTR+1), width of the internal instruction counter (derived; not overridden).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pixel_start_i  in  1  single-cycle pulse: start executing the program for the next pixel
blank_i  in  1  high during horizontal/vertical blanking; program loads may start only while high
wr_valid_i  in  1  program byte available
wr_data_i  in  8  program byte, first instruction first
wr_ready_o  out  1  byte accepted when wr_valid_i && wr_ready_o
mem_shift_o  out  1  to memory shift input
mem_load_o  out  1  to memory load input
mem_instr_o  out  8  to memory instr input
exec_o  out  1  memory output holds a valid instruction for the core this cycle
pixel_done_o  out  1  single-cycle pulse after the last instruction of a pixel
load_done_o  out  1  single-cycle pulse after the last program byte is accepted
overrun_o  out  1  sticky error: pixel_start_i arrived while busy; cleared only by reset

Behaviour:
States: IDLE, EXEC, LOAD. Encoding is an enum in the package.

Reset:
- state = IDLE, counter = 0.
- All outputs are 0.
- overrun_o = 0.

IDLE:
- All strobes are 0.
- If pixel_start_i = 1: go to EXEC, counter = 0. This takes priority over a load.
- Else if wr_valid_i && blank_i: go to LOAD, counter = 0. No byte is accepted in the transition cycle.

EXEC:
- Every cycle (subject to the optional feature): exec_o = 1, mem_shift_o = 1, mem_load_o = 0, counter++.
- On the cycle with counter == NUM_INSTR-1 (the NUM_INSTR-th shift): next state = IDLE.
- The next cycle drives pixel_done_o = 1, in IDLE.
- Latency: pixel_start_i at cycle T gives exec_o at cycles T+1 .. T+NUM_INSTR and pixel_done_o at T+NUM_INSTR+1.
- The memory has rotated exactly NUM_INSTR times, so it is realigned.

LOAD:
- wr_ready_o = 1.
- On a handshake: mem_shift_o = 1, mem_load_o = 1, mem_instr_o = wr_data_i, counter++.
- Without a handshake: no shift, and mem_instr_o = 0.
- After handshake number NUM_INSTR: go to IDLE, with load_done_o = 1 on the next cycle.
- The byte accepted first ends in memory entry 0.
- Once entered, LOAD runs to completion even if blank_i falls. A partial load would misalign the memory.

Concurrent events:
- pixel_start_i in EXEC or LOAD sets overrun_o and is otherwise ignored. No queueing.
- pixel_start_i on the same cycle as pixel_done_o (state IDLE) is accepted normally.
- wr_valid_i while blank_i = 0 in IDLE is held off: wr_ready_o = 0.
- Reset mid-operation returns to IDLE immediately. The memory resets alongside and reloads its default program, so no realignment is needed.
- mem_load_o = 1 only in LOAD, and only with mem_shift_o = 1.

Optional Feature:
Macro: SHADER_SEQ_SINGLE_STEP_EN.

Defined:
- Adds ports step_mode_i (in, 1) and step_i (in, 1).
- In EXEC with step_mode_i = 1: exec_o, mem_shift_o and counter++ occur only on cycles with step_i = 1. Other cycles hold all three at 0.
- With step_mode_i = 0: behaviour is identical to the macro-off build.

Undefined:
- The ports do not exist; EXEC advances every cycle.

Decomposition:
- Package shader_seq_pkg holds: the state enum (state_t: IDLE, EXEC, LOAD), the NUM_INSTR_DEFAULT = 10 localparam, and instr_t (logic [7:0]).
- No sub-module. The sequencer does not instantiate shader_memory; the parent connects the two.
- The bench instantiates both, plus a reference shift-register model.

Test Plan:
- Reset, then pixel_start_i pulse at cycle 5 -> exec_o high at cycles 6–15; pixel_done_o at 16; memory entry 0 after completion equals its value before the pixel (8'b00_0100_00).
- blank_i = 1, stream bytes 0x01..0x0A with wr_valid_i toggling every other cycle -> 10 handshakes; load_done_o one cycle after the 10th; memory entries 0..9 = 0x01..0x0A; a subsequent pixel drives mem_instr sequence 0x01..0x0A.
- pixel_start_i at cycle 3 of EXEC, and again mid-LOAD -> overrun_o goes high and stays high; the EXEC/LOAD counts are unaffected (still 10 shifts).
- Same cycle in IDLE: pixel_start_i = 1, wr_valid_i = 1, blank_i = 1 -> EXEC entered; wr_ready_o stays 0 until after pixel_done_o.
- Assert rst_ni low after 4 bytes of a LOAD -> all outputs 0 asynchronously; on release the state is IDLE and the memory holds the default program.
- With SHADER_SEQ_SINGLE_STEP_EN, step_mode_i = 1, step_i pulsed every 3rd cycle -> exactly 10 exec_o pulses coincident with step_i; pixel_done_o after the 10th.
